// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, line level and default widths
// that the TX FIFO instantiation also uses.
package uart_pkg;

  localparam int unsigned DataSizeDef     = 8;
  localparam int unsigned BaudDivWidthDef = 16;

  localparam logic LineIdle = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; bit_end_o is high in the last clock of each bit.
module uart_baud_gen #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [Width-1:0] load_val_i,
  output logic             bit_end_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls bytes from the TX FIFO head and frames them as
// start / data (LSB first) / optional parity / 1-2 stop bits at a programmable bit period.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = DataSizeDef,
  parameter int unsigned BAUD_DIV_WIDTH = BaudDivWidthDef
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tx_en_i,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div_i,
  input  logic                      parity_en_i,
  input  logic                      parity_odd_i,
  input  logic                      stop2_i,
  input  logic [DATA_SIZE-1:0]      fifo_data_i,
  input  logic                      fifo_load_i,
  output logic                      fifo_pull_o,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic                      frame_done_o
);

  localparam int unsigned IdxW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_SIZE - 1);

  uart_state_e               state_q;
  logic [DATA_SIZE-1:0]      shift_q, shift_nxt;
  logic [IdxW-1:0]           bit_idx_q;
  logic [BAUD_DIV_WIDTH-1:0] div_m1_q, load_val;
  logic                      par_en_q, par_bit_q, stop2_q, stop_idx_q;
  logic                      tx_q, pull_q, busy_q, done_q;
  logic                      bit_end, restart, start_ok, last_stop, capture;

  always_comb begin
    start_ok  = tx_en_i & fifo_load_i;
    last_stop = bit_end & (~stop2_q | stop_idx_q);
    // A new byte is taken from idle or straight out of the final stop bit (no idle gap).
    capture   = start_ok & ((state_q == StIdle) | ((state_q == StStop) & last_stop));
    restart   = capture | (bit_end & (state_q != StIdle));
    shift_nxt = shift_q >> 1;
    if (capture) begin
      load_val = (baud_div_i == '0) ? '0 : baud_div_i - BAUD_DIV_WIDTH'(1);
    end else begin
      load_val = div_m1_q;
    end
  end

  uart_baud_gen #(
    .Width(BAUD_DIV_WIDTH)
  ) u_baud_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (restart),
    .load_val_i(load_val),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      div_m1_q   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= LineIdle;
      pull_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pull_q <= 1'b0;
      done_q <= 1'b0;
      if (capture) begin
        state_q    <= StStart;
        shift_q    <= fifo_data_i;
        bit_idx_q  <= '0;
        div_m1_q   <= load_val;
        par_en_q   <= parity_en_i;
        par_bit_q  <= (^fifo_data_i) ^ parity_odd_i;
        stop2_q    <= stop2_i;
        stop_idx_q <= 1'b0;
        tx_q       <= ~LineIdle;
        pull_q     <= 1'b1;
        busy_q     <= 1'b1;
        done_q     <= (state_q == StStop);
      end else if (bit_end) begin
        unique case (state_q)
          StStart: begin
            state_q <= StData;
            tx_q    <= shift_q[0];
          end
          StData: begin
            if (bit_idx_q == LastIdx) begin
              state_q <= par_en_q ? StParity : StStop;
              tx_q    <= par_en_q ? par_bit_q : LineIdle;
            end else begin
              shift_q   <= shift_nxt;
              tx_q      <= shift_nxt[0];
              bit_idx_q <= bit_idx_q + IdxW'(1);
            end
          end
          StParity: begin
            state_q <= StStop;
            tx_q    <= LineIdle;
          end
          StStop: begin
            if (stop2_q && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_pull_o  = pull_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: hand-computed vector table, directed corner
// sequences and randomized streams compared against a frame-level reference model.
module tb_uart_tx_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          tx_en_i;
  logic [BW-1:0] baud_div_i;
  logic          parity_en_i;
  logic          parity_odd_i;
  logic          stop2_i;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_load_i = 1'b0;
  logic          fifo_pull_o;
  logic          tx_o;
  logic          busy_o;
  logic          frame_done_o;

  always #5 clk_i = ~clk_i;

  uart_tx_serializer #(
    .DATA_SIZE     (DW),
    .BAUD_DIV_WIDTH(BW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tx_en_i     (tx_en_i),
    .baud_div_i  (baud_div_i),
    .parity_en_i (parity_en_i),
    .parity_odd_i(parity_odd_i),
    .stop2_i     (stop2_i),
    .fifo_data_i (fifo_data_i),
    .fifo_load_i (fifo_load_i),
    .fifo_pull_o (fifo_pull_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] sent[$];
  int         pull_k[$];
  logic       par_seen;

  // FIFO model: head advances at the end of the pull cycle.
  always @(negedge clk_i) begin
    if (fifo_pull_o === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_load_i = (fifo_q.size() != 0);
    fifo_data_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  typedef struct {
    int         dv;
    int         pe;
    int         po;
    int         s2;
    logic [7:0] data;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int dv, input int pe, input int po, input int s2);
    baud_div_i   = BW'(dv);
    parity_en_i  = (pe != 0);
    parity_odd_i = (po != 0);
    stop2_i      = (s2 != 0);
  endtask

  task automatic wait_pull();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (fifo_pull_o === 1'b1) seen = 1'b1;
    end
    chk("pull_seen", seen, 1'b1);
  endtask

  // Expected line level k clocks after the first START cycle of a stream of sent[] bytes.
  function automatic logic exp_bit(input int k, input int d, input int pe, input int po,
                                   input int l);
    int         f = k / l;
    int         b = (k % l) / d;
    logic [7:0] by = sent[f];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (b == 9 && pe != 0) return (^by) ^ (po != 0);
    return 1'b1;
  endfunction

  // Called with the first pull cycle already sampled (k = 0).
  task automatic check_stream(input int dv, input int pe, input int po, input int s2,
                              input bit scramble, input bit drop_en, output int done_at);
    int d, l, total;
    d = (dv == 0) ? 1 : dv;
    l = d * (10 + pe + s2);
    total = l * sent.size();
    done_at = -1;
    pull_k.delete();
    for (int k = 0; k <= total; k++) begin
      if (k > 0) step();
      chk($sformatf("tx[%0d]", k), tx_o, (k < total) ? exp_bit(k, d, pe, po, l) : 1'b1);
      chk($sformatf("pull[%0d]", k), fifo_pull_o, (k < total) && (k % l == 0));
      chk($sformatf("done[%0d]", k), frame_done_o, (k > 0) && (k % l == 0));
      chk($sformatf("busy[%0d]", k), busy_o, k < total);
      if (fifo_pull_o === 1'b1) pull_k.push_back(k);
      if (frame_done_o === 1'b1 && done_at < 0) done_at = k;
      if (k == d * 9 + d / 2) par_seen = tx_o;
      if (scramble && k == 1) begin
        set_cfg($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1));
      end
      if (drop_en && k == 5) tx_en_i = 1'b0;
    end
  endtask

  initial begin
    int done_at;
    int pulls_before;

    vecs[0] = '{4, 0, 0, 0, 8'h55, 40, 1'b1};
    vecs[1] = '{4, 1, 0, 0, 8'hA5, 44, 1'b0};
    vecs[2] = '{4, 1, 1, 0, 8'hA5, 44, 1'b1};
    vecs[3] = '{0, 0, 0, 0, 8'h3C, 10, 1'b1};
    vecs[4] = '{2, 0, 0, 1, 8'h01, 22, 1'b1};
    vecs[5] = '{3, 1, 1, 1, 8'h07, 36, 1'b0};
    vecs[6] = '{1, 1, 0, 1, 8'hFF, 12, 1'b0};

    rst_i   = 1'b1;
    tx_en_i = 1'b0;
    set_cfg(4, 0, 0, 0);
    step();
    step();
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_pull", fifo_pull_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", frame_done_o, 1'b0);
    rst_i = 1'b0;

    // Enabled but FIFO empty: line stays idle.
    tx_en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_tx", tx_o, 1'b1);
      chk("idle_pull", fifo_pull_o, 1'b0);
      chk("idle_busy", busy_o, 1'b0);
    end

    // Data present but transmitter disabled: no frame starts.
    tx_en_i = 1'b0;
    fifo_q.push_back(8'h96);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("gated_pull", fifo_pull_o, 1'b0);
      chk("gated_tx", tx_o, 1'b1);
    end
    sent.delete();
    sent.push_back(8'h96);
    tx_en_i = 1'b1;
    wait_pull();
    check_stream(4, 0, 0, 0, 1'b0, 1'b0, done_at);

    // Hand-computed vector table.
    foreach (vecs[i]) begin
      set_cfg(vecs[i].dv, vecs[i].pe, vecs[i].po, vecs[i].s2);
      sent.delete();
      sent.push_back(vecs[i].data);
      fifo_q.push_back(vecs[i].data);
      wait_pull();
      check_stream(vecs[i].dv, vecs[i].pe, vecs[i].po, vecs[i].s2, 1'b0, 1'b0, done_at);
      chk_int($sformatf("vec%0d_len", i), done_at, vecs[i].exp_len);
      chk($sformatf("vec%0d_bit9", i), par_seen, vecs[i].exp_par);
    end

    // Three back-to-back 8N2 frames at D=2.
    set_cfg(2, 0, 0, 1);
    sent.delete();
    sent.push_back(8'h01);
    sent.push_back(8'h80);
    sent.push_back(8'hFF);
    foreach (sent[i]) fifo_q.push_back(sent[i]);
    wait_pull();
    check_stream(2, 0, 0, 1, 1'b0, 1'b0, done_at);
    chk_int("b2b_pulls", pull_k.size(), 3);
    if (pull_k.size() == 3) begin
      chk_int("b2b_gap1", pull_k[1] - pull_k[0], 22);
      chk_int("b2b_gap2", pull_k[2] - pull_k[1], 22);
    end

    // Reset during data bit 3 aborts the frame; next byte then goes out normally.
    set_cfg(4, 0, 0, 0);
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h5A);
    wait_pull();
    for (int i = 0; i < 17; i++) step();
    rst_i = 1'b1;
    step();
    chk("abort_tx", tx_o, 1'b1);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", frame_done_o, 1'b0);
    chk("abort_pull", fifo_pull_o, 1'b0);
    rst_i = 1'b0;
    wait_pull();
    chk("restart_done", frame_done_o, 1'b0);
    sent.delete();
    sent.push_back(8'h5A);
    check_stream(4, 0, 0, 0, 1'b0, 1'b0, done_at);

    // Enable dropped mid-frame: frame completes, nothing further is pulled.
    set_cfg(4, 1, 0, 0);
    fifo_q.push_back(8'h3E);
    fifo_q.push_back(8'h71);
    sent.delete();
    sent.push_back(8'h3E);
    wait_pull();
    check_stream(4, 1, 0, 0, 1'b0, 1'b1, done_at);
    pulls_before = fifo_q.size();
    for (int i = 0; i < 30; i++) begin
      step();
      chk("noen_pull", fifo_pull_o, 1'b0);
      chk("noen_tx", tx_o, 1'b1);
      chk("noen_busy", busy_o, 1'b0);
    end
    chk_int("noen_fifo_left", fifo_q.size(), 1);
    chk_int("noen_fifo_stable", fifo_q.size(), pulls_before);
    sent.delete();
    sent.push_back(8'h71);
    tx_en_i = 1'b1;
    wait_pull();
    check_stream(4, 1, 0, 0, 1'b0, 1'b0, done_at);

    // Randomized streams; single-byte runs also scramble the config inputs mid-frame.
    for (int it = 0; it < 8; it++) begin
      int dv, pe, po, s2, n;
      dv = $urandom_range(0, 5);
      pe = $urandom_range(0, 1);
      po = $urandom_range(0, 1);
      s2 = $urandom_range(0, 1);
      n  = $urandom_range(1, 3);
      set_cfg(dv, pe, po, s2);
      sent.delete();
      for (int j = 0; j < n; j++) sent.push_back(8'($urandom_range(0, 255)));
      foreach (sent[j]) fifo_q.push_back(sent[j]);
      wait_pull();
      check_stream(dv, pe, po, s2, n == 1, 1'b0, done_at);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation timeout");
  end

endmodule
